// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   mode_e       : overlap input encoding (1 = overlapping, 0 = non-overlapping)
//   DEF_PATTERN  : pattern loaded at reset (the legacy "1011" detector pattern)
//   fill_w()     : width needed to count 0..pat_w valid history bits
package seqdet_pkg;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   inc      : add one this cycle (held at all-ones once saturated)
//   clr      : clear; when inc is also set the result is 1 (clear, then count)
//   cnt      : current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Shifts in one bit per in_valid cycle (first bit received ends up in the
// pattern MSB) and pulses match for one cycle on every occurrence of the
// runtime-loadable pattern; match_cnt saturates.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : in_bit is sampled this cycle
//   in_bit    : serial data bit
//   overlap   : 1 = overlapping matches, 0 = restart after each match
//   pat_load  : load pat_in as new pattern (clears history, drops in_bit)
//   pat_in    : new pattern value
//   cnt_clr   : clear match_cnt
//   match     : registered one-cycle pulse per detected occurrence
//   match_cnt : saturating match count
//   pattern   : currently active pattern
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern
);

  localparam int               FILL_W    = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  hist_q,    hist_d;
  logic [FILL_W-1:0] fill_q,    fill_d;
  logic              match_q,   match_d;

  logic              accept;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  always_comb begin
    accept     = in_valid & ~pat_load;
    hist_shift = {hist_q[PAT_W-2:0], in_bit};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // The fill counter guards against matching a partially filled history
    // (e.g. an all-zero pattern against the cleared shift register).
    hit        = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern_q);

    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d  = hist_shift;
      fill_d  = (hit && (mode_e'(overlap) == MODE_NONOVERLAP)) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
    end
  end

  // Counter sees the combinational hit so match_cnt updates on the same
  // edge that raises match.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  assign match   = match_q;
  assign pattern = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded bench for seq_detector_param (PAT_W=4, CNT_W=2).
// The driver pushes the hand-computed outputs expected after each driven
// cycle; the monitor pops and compares one entry per clock.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = '0;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic [1:0] match_cnt;
  logic [3:0] pattern;

  seq_detector_param #(
    .PAT_W   (4),
    .CNT_W   (2),
    .DEF_PAT (4'b1011)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .match_cnt (match_cnt),
    .pattern   (pattern)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         tests  = 0;
  int         failed = 0;
  logic [3:0] pat_exp = 4'b1011;
  logic       ov = 1'b1;

  // Monitor: one expected entry per driven cycle, checked 1 time unit after the edge.
  initial begin
    logic [6:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        tests++;
        if ({match, match_cnt, pattern} !== e) begin
          failed++;
          $display("FAIL %s: got match=%b cnt=%0d pat=%b, expected match=%b cnt=%0d pat=%b",
                   nm, match, match_cnt, pattern, e[6], e[5:4], e[3:0]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic b, input logic pl,
                      input logic [3:0] pi, input logic cc,
                      input logic em, input logic [1:0] ec, input string nm);
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; overlap = ov;
    pat_load = pl; pat_in = pi; cnt_clr = cc;
    exp_q.push_back({em, ec, pat_exp});
    name_q.push_back(nm);
  endtask

  task automatic bitv(input logic b, input logic em, input logic [1:0] ec, input string nm);
    step(1'b0, 1'b1, b, 1'b0, 4'b0000, 1'b0, em, ec, nm);
  endtask

  task automatic idle(input logic [1:0] ec, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, ec, nm);
  endtask

  task automatic do_reset(input string nm);
    pat_exp = 4'b1011;
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, nm);
  endtask

  initial begin
    // reset defaults
    do_reset("t0_reset_a");
    do_reset("t0_reset_b");

    // T1 overlapping: 1011011 -> hits on bits 4 and 7
    ov = 1'b1;
    bitv(1'b1, 1'b0, 2'd0, "t1_b1");
    bitv(1'b0, 1'b0, 2'd0, "t1_b2");
    bitv(1'b1, 1'b0, 2'd0, "t1_b3");
    bitv(1'b1, 1'b1, 2'd1, "t1_b4_hit");
    bitv(1'b0, 1'b0, 2'd1, "t1_b5");
    bitv(1'b1, 1'b0, 2'd1, "t1_b6");
    bitv(1'b1, 1'b1, 2'd2, "t1_b7_hit");
    idle(2'd2, "t1_after");

    // T2 non-overlapping: 1011011 -> one hit, then 1011 -> second hit
    do_reset("t2_reset");
    ov = 1'b0;
    bitv(1'b1, 1'b0, 2'd0, "t2_b1");
    bitv(1'b0, 1'b0, 2'd0, "t2_b2");
    bitv(1'b1, 1'b0, 2'd0, "t2_b3");
    bitv(1'b1, 1'b1, 2'd1, "t2_b4_hit");
    bitv(1'b0, 1'b0, 2'd1, "t2_b5");
    bitv(1'b1, 1'b0, 2'd1, "t2_b6");
    bitv(1'b1, 1'b0, 2'd1, "t2_b7_nohit");
    bitv(1'b1, 1'b0, 2'd1, "t2_b8");
    bitv(1'b0, 1'b0, 2'd1, "t2_b9");
    bitv(1'b1, 1'b0, 2'd1, "t2_b10");
    bitv(1'b1, 1'b1, 2'd2, "t2_b11_hit");
    idle(2'd2, "t2_after");

    // T3 valid gaps: 1,_,0,_,_,1,1
    do_reset("t3_reset");
    ov = 1'b1;
    bitv(1'b1, 1'b0, 2'd0, "t3_b1");
    idle(2'd0, "t3_gap1");
    bitv(1'b0, 1'b0, 2'd0, "t3_b2");
    idle(2'd0, "t3_gap2");
    idle(2'd0, "t3_gap3");
    bitv(1'b1, 1'b0, 2'd0, "t3_b3");
    bitv(1'b1, 1'b1, 2'd1, "t3_b4_hit");
    idle(2'd1, "t3_after");

    // T4 pattern load drops the concurrent bit
    pat_exp = 4'b0110;
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd1, "t4_load1");
    bitv(1'b1, 1'b0, 2'd1, "t4_drop_b1");
    bitv(1'b1, 1'b0, 2'd1, "t4_drop_b2");
    bitv(1'b0, 1'b0, 2'd1, "t4_drop_b3_nohit");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd1, "t4_load2");
    bitv(1'b0, 1'b0, 2'd1, "t4_b1");
    bitv(1'b1, 1'b0, 2'd1, "t4_b2");
    bitv(1'b1, 1'b0, 2'd1, "t4_b3");
    bitv(1'b0, 1'b1, 2'd2, "t4_b4_hit");
    bitv(1'b1, 1'b0, 2'd2, "t4_old_b1");
    bitv(1'b0, 1'b0, 2'd2, "t4_old_b2");
    bitv(1'b1, 1'b0, 2'd2, "t4_old_b3");
    bitv(1'b1, 1'b0, 2'd2, "t4_old_b4");

    // T5 saturation at 3 and clear priority
    do_reset("t5_reset");
    ov = 1'b1;
    bitv(1'b1, 1'b0, 2'd0, "t5_b1");
    bitv(1'b0, 1'b0, 2'd0, "t5_b2");
    bitv(1'b1, 1'b0, 2'd0, "t5_b3");
    bitv(1'b1, 1'b1, 2'd1, "t5_hit1");
    for (int unsigned h = 2; h <= 5; h++) begin
      bitv(1'b0, 1'b0, (h > 3) ? 2'd3 : 2'(h - 1), "t5_zero");
      bitv(1'b1, 1'b0, (h > 3) ? 2'd3 : 2'(h - 1), "t5_one");
      bitv(1'b1, 1'b1, (h > 3) ? 2'd3 : 2'(h), "t5_hit_sat");
    end
    bitv(1'b0, 1'b0, 2'd3, "t5_c_b1");
    bitv(1'b1, 1'b0, 2'd3, "t5_c_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, "t5_clr_with_hit");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, "t5_clr_alone");

    // T6 mid-stream reset discards partial match; all-zero pattern
    do_reset("t6_reset");
    bitv(1'b1, 1'b0, 2'd0, "t6_b1");
    bitv(1'b0, 1'b0, 2'd0, "t6_b2");
    bitv(1'b1, 1'b0, 2'd0, "t6_b3");
    do_reset("t6_mid_reset");
    bitv(1'b1, 1'b0, 2'd0, "t6_after_reset_nohit");
    pat_exp = 4'b0000;
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, "t6_load_zero");
    bitv(1'b0, 1'b0, 2'd0, "t6_z1");
    bitv(1'b0, 1'b0, 2'd0, "t6_z2");
    bitv(1'b0, 1'b0, 2'd0, "t6_z3_nohit");
    bitv(1'b0, 1'b1, 2'd1, "t6_z4_hit");
    bitv(1'b0, 1'b1, 2'd2, "t6_z5_overlap_hit");
    idle(2'd2, "t6_after");

    @(negedge clk);
    in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
